// File: rtl/sqrt_prenorm_pkg.sv
// Shared constants and helpers for the sqrt pre-normaliser and its neighbours
// in the DoA vector chain.
package sqrt_prenorm_pkg;

    // Default widths of the stage as used in the DoA chain.
    localparam int DIN_WIDTH_DEF  = 16;
    localparam int DIN_POINT_DEF  = 15;
    localparam int DOUT_WIDTH_DEF = 16;
    localparam int EXP_WIDTH_DEF  = 5;

    // Power word width: re^2 + im^2 needs twice the input width.
    localparam int P_DEF = 2 * DIN_WIDTH_DEF;

    // Power word at default widths, handy for neighbouring blocks and models.
    typedef logic [P_DEF-1:0] power_t;

    // Bits needed to encode values 0 .. value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                bits = bits + 1;
                rem  = rem >> 1;
            end else begin
                bits = bits;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/sqrt_prenorm_if.sv
// Sample-in / normalised-power-out bundle of the sqrt pre-normaliser.
// The master side sources samples; the slave side is the normaliser itself.
interface sqrt_prenorm_if
    import sqrt_prenorm_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF
) ();

    logic signed [DIN_WIDTH-1:0]  din_re;
    logic signed [DIN_WIDTH-1:0]  din_im;
    logic                         din_valid;
    logic        [DOUT_WIDTH-1:0] dout;
    logic        [EXP_WIDTH-1:0]  dout_exp;
    logic                         dout_zero;
    logic                         dout_valid;

    modport master (
        output din_re,
        output din_im,
        output din_valid,
        input  dout,
        input  dout_exp,
        input  dout_zero,
        input  dout_valid
    );

    modport slave (
        input  din_re,
        input  din_im,
        input  din_valid,
        output dout,
        output dout_exp,
        output dout_zero,
        output dout_valid
    );

endinterface

// File: rtl/sqrt_prenorm_lzc_even.sv
// Combinational leading-zero count over a W-bit word, rounded down to an
// even value so that a left shift by the result is a whole power of four.
// An all-zero word yields W (rounded down to even).
module sqrt_prenorm_lzc_even
    import sqrt_prenorm_pkg::*;
#(
    parameter  int W   = P_DEF,
    localparam int SHW = clog2(W + 1)
) (
    input  logic [W-1:0]   data_i,
    output logic [SHW-1:0] shift_o
);

    logic [SHW-1:0] lzc_s;

    // Scan upward so the highest set bit is the last one to set the count.
    always_comb begin
        lzc_s = SHW'(W);
        for (int i = 0; i < W; i++) begin
            lzc_s = data_i[i] ? SHW'(W - 1 - i) : lzc_s;
        end
    end

    // Clearing the LSB keeps the shift even; the exponent is then shift/2.
    assign shift_o = lzc_s & ~SHW'(1);

endmodule

// File: rtl/sqrt_prenorm.sv
// Sqrt pre-normaliser: computes re^2+im^2, normalises it by an even left
// shift so the leading one sits in the top two bits, and emits the top
// DOUT_WIDTH bits as the sqrt ROM address plus a half-shift exponent.
// Five-stage pipeline, one sample per cycle, no backpressure.
module sqrt_prenorm
    import sqrt_prenorm_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int DIN_POINT  = DIN_POINT_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    sqrt_prenorm_if.slave bus
);

    localparam int P   = 2 * DIN_WIDTH;
    localparam int SHW = clog2(P + 1);
    // Fractional bits of the power word; the downstream ROM scaling uses it.
    localparam int POWER_POINT = 2 * DIN_POINT;

    // Stage 1: captured inputs.
    logic signed [DIN_WIDTH-1:0] re_q,  re_d;
    logic signed [DIN_WIDTH-1:0] im_q,  im_d;
    logic                        v1_q,  v1_d;
    // Stage 2: squares.
    logic [P-1:0]                sq_re_q, sq_re_d;
    logic [P-1:0]                sq_im_q, sq_im_d;
    logic                        v2_q,  v2_d;
    // Stage 3: power.
    logic [P-1:0]                sum_q, sum_d;
    logic                        v3_q,  v3_d;
    // Stage 4: power and its even normalising shift.
    logic [P-1:0]                sum4_q, sum4_d;
    logic [SHW-1:0]              shift_q, shift_d;
    logic                        v4_q,  v4_d;
    // Stage 5: outputs.
    logic [DOUT_WIDTH-1:0]       dout_q, dout_d;
    logic [EXP_WIDTH-1:0]        exp_q, exp_d;
    logic                        zero_q, zero_d;
    logic                        v5_q,  v5_d;

    logic signed [P-1:0]         re_ext_s;
    logic signed [P-1:0]         im_ext_s;
    logic [SHW-1:0]              lzc_shift_s;
    logic [P-1:0]                norm_s;

    sqrt_prenorm_lzc_even #(
        .W (P)
    ) u_lzc (
        .data_i  (sum_q),
        .shift_o (lzc_shift_s)
    );

    // Next-state of every pipeline stage; invalid samples flow through too.
    always_comb begin
        re_d     = bus.din_re;
        im_d     = bus.din_im;
        v1_d     = bus.din_valid;

        // Sign-extend before multiplying so the square is formed at full width;
        // (-2^(N-1))^2 is positive and still fits.
        re_ext_s = P'(re_q);
        im_ext_s = P'(im_q);
        sq_re_d  = $unsigned(re_ext_s * re_ext_s);
        sq_im_d  = $unsigned(im_ext_s * im_ext_s);
        v2_d     = v1_q;

        // Maximum sum is 2^(P-1), so the P-bit add never wraps.
        sum_d    = sq_re_q + sq_im_q;
        v3_d     = v2_q;

        sum4_d   = sum_q;
        shift_d  = lzc_shift_s;
        v4_d     = v3_q;

        // A shift of P clears the word, which gives dout=0 for zero power.
        norm_s   = sum4_q << shift_q;
        dout_d   = DOUT_WIDTH'(norm_s >> (P - DOUT_WIDTH));
        exp_d    = EXP_WIDTH'(shift_q >> 1);
        zero_d   = (sum4_q == {P{1'b0}});
        v5_d     = v4_q;
    end

    // Pipeline registers; reset discards every in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q    <= '0;
            im_q    <= '0;
            v1_q    <= 1'b0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            v2_q    <= 1'b0;
            sum_q   <= '0;
            v3_q    <= 1'b0;
            sum4_q  <= '0;
            shift_q <= '0;
            v4_q    <= 1'b0;
            dout_q  <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            v5_q    <= 1'b0;
        end else begin
            re_q    <= re_d;
            im_q    <= im_d;
            v1_q    <= v1_d;
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            v2_q    <= v2_d;
            sum_q   <= sum_d;
            v3_q    <= v3_d;
            sum4_q  <= sum4_d;
            shift_q <= shift_d;
            v4_q    <= v4_d;
            dout_q  <= dout_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            v5_q    <= v5_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_exp   = exp_q;
    assign bus.dout_zero  = zero_q;
    assign bus.dout_valid = v5_q;

endmodule
